// File: rtl/result_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module      : result_capture_fifo
// Description : Small synchronous FIFO that captures 4-bit results from the
//               conditional-result datapath. It uses valid/ready handshakes on
//               both sides and reports occupancy and the peak value accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module result_capture_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] peak,
  input  logic             peak_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_peak;

  logic w_push;
  logic w_pop;
  logic w_not_full;
  logic w_not_empty;

  // Handshake flags come only from registered occupancy. in_ready ignores
  // out_ready, so a full FIFO never passes a word straight through.
  always_comb begin
    w_not_full  = (r_count != C_FULL_CNT);
    w_not_empty = (r_count != '0);
    w_push      = in_valid && w_not_full;
    w_pop       = out_ready && w_not_empty;
  end

  // Storage write. Reset blocks the write so no word is accepted on that edge.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Pointers and occupancy. Pointers are exactly log2(DEPTH) bits and wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + C_CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - C_CNT_ONE;
      end
    end
  end

  // Running peak. A clear takes effect before the compare, so a push in the
  // same cycle as a clear becomes the new peak.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_peak <= '0;
    end else if (peak_clr) begin
      r_peak <= w_push ? in_data : '0;
    end else if (w_push && (in_data > r_peak)) begin
      r_peak <= in_data;
    end
  end

  // Head word is masked to zero while empty, so the uncleared storage never
  // shows stale or unknown data after reset.
  always_comb begin
    in_ready  = w_not_full;
    out_valid = w_not_empty;
    out_data  = w_not_empty ? r_mem[r_rd_ptr] : '0;
    count     = r_count;
    peak      = r_peak;
  end

endmodule
`default_nettype wire
